softmax_max_subtract: RTL

- Downstream companion of the pipelined max finder in the softmax32Elements datapath.
- Buffers each input vector while its maximum is computed. When the matching max arrives, it emits the vector with the max subtracted from every element, x_i - max, saturated to BIT_WIDTH.
- Feeds the exponent stage, whose inputs must be ≤ 0.
- Lives beside the max finder; both receive the same i_valid/i_data stream.

---
 rtl/softmax_max_subtract.sv | 106 ++++++++++
 1 files changed

// File: rtl/softmax_max_subtract.sv
// rtl/softmax_max_subtract.sv - buffers vectors until their max arrives, emits saturated x_i - max
// Optional error flags: define SOFTMAX_SUB_ERR_FLAGS_EN to add sticky o_overflow / o_underflow.
module softmax_max_subtract #(
  parameter int BIT_WIDTH  = 16,
  parameter int N          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  input  logic [N*BIT_WIDTH-1:0]          i_data,
  input  logic                            i_maxValid,
  input  logic [BIT_WIDTH-1:0]            i_dataMax,
  output logic                            o_valid,
  output logic [N*BIT_WIDTH-1:0]          o_data,
  output logic [$clog2(FIFO_DEPTH):0]     o_count
`ifdef SOFTMAX_SUB_ERR_FLAGS_EN
  ,
  output logic                            o_overflow,
  output logic                            o_underflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = BIT_WIDTH;

  logic [N*W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [N*W-1:0] head;
  logic [N*W-1:0] sub_data;

  // Differences are formed one bit wider so x - max can never wrap before clamping.
  function automatic logic [W-1:0] sat_diff(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W:0] d;
    d = {x[W-1], x} - {m[W-1], m};
    if (d[W] && !d[W-1])
      return {1'b1, {(W-1){1'b0}}};
    else if (!d[W])
      return '0;
    else
      return d[W-1:0];
  endfunction

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = i_maxValid && !empty;
  assign push  = i_valid && (!full || pop);
  assign head  = mem[rptr];
  assign o_count = count;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < N; i++)
      sub_data[i*W +: W] = sat_diff(head[i*W +: W], i_dataMax);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= pop;
      if (push)
        wptr <= wptr + AW'(1);
      if (pop) begin
        rptr   <= rptr + AW'(1);
        o_data <= sub_data;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst)
      mem[wptr] <= i_data;
  end

`ifdef SOFTMAX_SUB_ERR_FLAGS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_valid && !push)
        o_overflow <= 1'b1;
      if (i_maxValid && empty)
        o_underflow <= 1'b1;
    end
  end
`endif

endmodule
